// File: rtl/fifo_wr_dispatch.sv
// Write side of the per-switch FIFO bank: decodes the header unit address and
// steers each packet into one switch FIFO. Optional drop counter: FIFO_WR_DROP_CNT_EN.
module fifo_wr_dispatch #(
   parameter int                   NUM_SW_INST = 5,
   parameter int                   W_WIDTH     = 8,
   parameter logic [W_WIDTH-1:0]   ADDR_BASE   = 8'h10,
   parameter int                   SPAN_LOG2   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [W_WIDTH-1:0]      in_data,
   input  logic                    in_sop,
   input  logic                    in_eop,
   output logic                    in_ready,
   input  logic [NUM_SW_INST-1:0]  afull,
   output logic [NUM_SW_INST-1:0]  wr_en,
   output logic [W_WIDTH-1:0]      wr_data,
   output logic                    proto_err
`ifdef FIFO_WR_DROP_CNT_EN
   ,
   output logic [15:0]             drop_cnt
`endif
);

   // state   | meaning
   // IDLE    | waiting for a header word
   // FORWARD | writing payload into FIFO sel
   // DROP    | discarding payload of an out-of-range packet
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FORWARD = 2'd1;
   localparam logic [1:0] DROP    = 2'd2;

   localparam int SEL_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

   logic [1:0]         state, state_nxt;
   logic [SEL_W-1:0]   sel, sel_nxt;
   logic [SEL_W-1:0]   tgt;
   logic [W_WIDTH:0]   off_ext;
   logic [W_WIDTH:0]   idx_ext;
   logic [SEL_W-1:0]   hit_idx;
   logic               hit;
   logic               accept;
   logic               wr_fire;
   logic               err_fire;

   // Decode at W_WIDTH+1 bits so a header below ADDR_BASE shows up as a borrow.
   assign off_ext = {1'b0, in_data} - {1'b0, ADDR_BASE};
   assign idx_ext = off_ext >> SPAN_LOG2;
   assign hit     = !off_ext[W_WIDTH] && (idx_ext < (W_WIDTH+1)'(NUM_SW_INST));
   assign hit_idx = idx_ext[SEL_W-1:0];
   assign accept  = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      in_ready  = 1'b1;
      wr_fire   = 1'b0;
      err_fire  = 1'b0;
      tgt       = sel;
      case (state)
         IDLE: begin
            if (in_valid && in_sop && hit) begin
               in_ready = !afull[hit_idx];
               if (accept) begin
                  wr_fire   = 1'b1;
                  tgt       = hit_idx;
                  sel_nxt   = hit_idx;
                  state_nxt = in_eop ? IDLE : FORWARD;
               end
            end else if (in_valid && in_sop) begin
               state_nxt = in_eop ? IDLE : DROP;
            end else if (in_valid) begin
               err_fire = 1'b1;
            end
         end
         FORWARD: begin
            in_ready = !afull[sel];
            if (accept) begin
               wr_fire  = 1'b1;
               err_fire = in_sop;
               if (in_eop) state_nxt = IDLE;
            end
         end
         DROP: begin
            if (in_valid) begin
               err_fire = in_sop;
               if (in_eop) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         wr_en     <= '0;
         wr_data   <= '0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         wr_en     <= wr_fire ? (NUM_SW_INST'(1) << tgt) : '0;
         if (wr_fire) wr_data <= in_data;
         proto_err <= err_fire;
      end
   end

`ifdef FIFO_WR_DROP_CNT_EN
   logic drop_inc;
   assign drop_inc = in_valid && (state == IDLE) && in_sop && !hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           drop_cnt <= '0;
      else if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_wr_dispatch.sv
// Bench for fifo_wr_dispatch: directed packets plus a random packet stream,
// checked against a packet-level reference model.
module tb_fifo_wr_dispatch;
   localparam int NSW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [7:0]      in_data = '0;
   logic            in_sop = 1'b0;
   logic            in_eop = 1'b0;
   logic            in_ready;
   logic [NSW-1:0]  afull = '0;
   logic [NSW-1:0]  wr_en;
   logic [7:0]      wr_data;
   logic            proto_err;
`ifdef FIFO_WR_DROP_CNT_EN
   logic [15:0]     drop_cnt;
`endif

   fifo_wr_dispatch dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
      .in_ready(in_ready), .afull(afull),
      .wr_en(wr_en), .wr_data(wr_data), .proto_err(proto_err)
`ifdef FIFO_WR_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference: mode -1 = between packets, -2 = discarding, else target FIFO.
   int             mode = -1;
   int             drops = 0;
   logic [NSW-1:0] exp_wr_en = '0;
   logic [7:0]     exp_wr_data = '0;
   logic           exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dec_idx(input logic [7:0] hdr);
      int off;
      off = int'(hdr) - 16;
      if (off < 0 || off / 16 >= NSW) return -1;
      return off / 16;
   endfunction

   task automatic check_outputs();
      chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
      if (exp_wr_en != '0) chk("wr_data", 32'(wr_data), 32'(exp_wr_data));
      chk("proto_err", 32'(proto_err), 32'(exp_err));
`ifdef FIFO_WR_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), (drops > 65535) ? 32'hFFFF : 32'(drops));
`endif
   endtask

   // One clock: check last cycle's registered results, present a word, check in_ready.
   task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic e,
                        input logic [NSW-1:0] af, output logic acc);
      logic rdy;
      int   idx;
      int   wt;
      @(posedge clk); #1;
      check_outputs();
      in_valid = v; in_data = d; in_sop = s; in_eop = e; afull = af;
      #1;
      idx = dec_idx(d);
      if (mode >= 0)                 rdy = !af[mode];
      else if (mode == -1 && s && idx >= 0) rdy = !af[idx];
      else                           rdy = 1'b1;
      if (v) chk("in_ready", 32'(in_ready), 32'(rdy));
      acc = v && rdy;
      wt = -1;
      exp_err = 1'b0;
      if (acc) begin
         if (mode == -1) begin
            if (s && idx >= 0) begin wt = idx; mode = e ? -1 : idx; end
            else if (s)        begin drops++;  mode = e ? -1 : -2; end
            else               exp_err = 1'b1;
         end else begin
            if (mode >= 0) wt = mode;
            exp_err = s;
            if (e) mode = -1;
         end
      end
      exp_wr_en = (wt >= 0) ? NSW'(1 << wt) : '0;
      if (wt >= 0) exp_wr_data = d;
   endtask

   task automatic send(input logic [7:0] d, input logic s, input logic e);
      logic acc;
      int   tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
         cycle(($urandom % 4) != 0, d, s, e,
               NSW'($urandom & $urandom), acc);
         tries++;
      end
      if (!acc) chk("accept_timeout", 32'(tries), 32'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'(0));
      chk("rst_proto_err", 32'(proto_err), 32'(0));
`ifdef FIFO_WR_DROP_CNT_EN
      chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
`endif
      mode = -1; drops = 0; exp_wr_en = '0; exp_err = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic acc;
      logic [7:0] hdr;
      int len;
      #2;
      do_reset();

      // 1: three-word packet to FIFO 1
      cycle(1, 8'h23, 1, 0, '0, acc);
      cycle(1, 8'hA1, 0, 0, '0, acc);
      cycle(1, 8'hA2, 0, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
      // 2: out-of-range header, packet dropped
      cycle(1, 8'h05, 1, 0, '0, acc);
      cycle(1, 8'h77, 0, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
      // 3: stall on afull[4] for three cycles after the header
      cycle(1, 8'h50, 1, 0, '0, acc);
      repeat (3) cycle(1, 8'hB1, 0, 0, 5'b10000, acc);
      cycle(1, 8'hB1, 0, 0, '0, acc);
      cycle(1, 8'hB2, 0, 0, '0, acc);
      cycle(1, 8'hB3, 0, 1, '0, acc);
      // 4: back-to-back single-word packets at range edges
      cycle(1, 8'h10, 1, 1, '0, acc);
      cycle(1, 8'h2F, 1, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
      // 5: reset mid-packet, remaining words arrive as strays
      cycle(1, 8'h33, 1, 0, '0, acc);
      cycle(1, 8'hC1, 0, 0, '0, acc);
      #3;
      do_reset();
      cycle(1, 8'hC2, 0, 0, '0, acc);
      cycle(1, 8'hC3, 0, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
      // 6: upper decode edge and first address past it
      cycle(1, 8'h5F, 1, 1, '0, acc);
      cycle(1, 8'h60, 1, 1, '0, acc);
      cycle(1, 8'hFF, 1, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
      // sop inside a packet is flagged but forwarded as payload
      cycle(1, 8'h41, 1, 0, '0, acc);
      cycle(1, 8'h42, 1, 0, '0, acc);
      cycle(1, 8'h43, 0, 1, '0, acc);

      // Random packet stream with occasional framing errors
      for (int p = 0; p < 600; p++) begin
         hdr = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(8'h10, 8'h5F));
         len = $urandom_range(1, 4);
         for (int w = 0; w < len; w++) begin
            send(w == 0 ? hdr : 8'($urandom),
                 (w == 0) ? ($urandom % 20 != 0) : ($urandom % 25 == 0),
                 w == len - 1);
         end
      end

`ifdef FIFO_WR_DROP_CNT_EN
      do_reset();
      for (int i = 0; i < 65540; i++) cycle(1, 8'h60, 1, 1, '0, acc);
      cycle(0, 8'h00, 0, 0, '0, acc);
`endif
      cycle(0, 8'h00, 0, 0, '0, acc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
